// File: rtl/phased_pwm_pkg.sv
// Shared constants and the saturation helper for the phased PWM array.
package phased_pwm_pkg;

    localparam int unsigned DEF_CTR_W  = 11;
    localparam int unsigned DEF_PERIOD = 1250;

    function automatic int unsigned clamp_max(input int unsigned val, input int unsigned lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/pwm_phase_channel.sv
// One PWM channel: phase-shifted local count compared against duty, registered output.
module pwm_phase_channel
    import phased_pwm_pkg::*;
#(
    parameter int unsigned CTR_W  = DEF_CTR_W,
    parameter int unsigned PERIOD = DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CTR_W-1:0] ctr,
    input  logic [CTR_W-1:0] duty,
    input  logic [CTR_W-1:0] phase,
    output logic             pwm_out
);

    logic [CTR_W-1:0] duty_eff;
    logic [CTR_W-1:0] phase_eff;
    logic [CTR_W:0]   local_cnt;
    logic             hit;

    // Duty clamped to PERIOD yields constant high since local_cnt never exceeds PERIOD-1.
    always_comb begin
        duty_eff  = CTR_W'(clamp_max(32'(duty), PERIOD));
        phase_eff = CTR_W'(clamp_max(32'(phase), PERIOD - 1));
        if (ctr >= phase_eff)
            local_cnt = {1'b0, ctr} - {1'b0, phase_eff};
        else
            local_cnt = {1'b0, ctr} + (CTR_W+1)'(PERIOD) - {1'b0, phase_eff};
        hit = local_cnt < {1'b0, duty_eff};
    end

    always_ff @(posedge clk) begin
        if (rst)
            pwm_out <= 1'b0;
        else
            pwm_out <= enable & hit;
    end

endmodule

// File: rtl/phased_pwm_array.sv
// Multi-channel phase-offset PWM: shared period counter, double-buffered per-channel settings.
module phased_pwm_array
    import phased_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CTR_W  = DEF_CTR_W,
    parameter int unsigned PERIOD = DEF_PERIOD,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CTR_W-1:0]  cfg_duty,
    input  logic [CTR_W-1:0]  cfg_phase,
    input  logic              commit,
    output logic              commit_pending,
    output logic              period_start,
    output logic [NUM_CH-1:0] pwm_out
);

    logic [CTR_W-1:0] ctr;
    logic [CTR_W-1:0] stg_duty      [NUM_CH];
    logic [CTR_W-1:0] stg_phase     [NUM_CH];
    logic [CTR_W-1:0] stg_duty_nxt  [NUM_CH];
    logic [CTR_W-1:0] stg_phase_nxt [NUM_CH];
    logic [CTR_W-1:0] act_duty      [NUM_CH];
    logic [CTR_W-1:0] act_phase     [NUM_CH];
    logic             last;
    logic             wr_en;
    logic             xfer;

    assign cfg_ready = ~commit_pending;
    assign last      = (ctr == CTR_W'(PERIOD - 1));
    assign wr_en     = cfg_valid & cfg_ready & (32'(cfg_ch) < NUM_CH);

    // A commit arriving on the last count of a period is honoured at that same boundary;
    // active regs load from the post-write staging view so a same-cycle write is included.
    always_comb begin
        xfer = enable ? ((commit_pending | commit) & last) : commit_pending;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            stg_duty_nxt[i]  = stg_duty[i];
            stg_phase_nxt[i] = stg_phase[i];
            if (wr_en && (32'(cfg_ch) == i)) begin
                stg_duty_nxt[i]  = cfg_duty;
                stg_phase_nxt[i] = cfg_phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr            <= '0;
            period_start   <= 1'b0;
            commit_pending <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stg_duty[i]  <= '0;
                stg_phase[i] <= '0;
                act_duty[i]  <= '0;
                act_phase[i] <= '0;
            end
        end else begin
            ctr            <= (!enable || last) ? '0 : ctr + CTR_W'(1);
            period_start   <= enable && (ctr == '0);
            commit_pending <= xfer ? 1'b0 : (commit_pending | commit);
            stg_duty       <= stg_duty_nxt;
            stg_phase      <= stg_phase_nxt;
            if (xfer) begin
                act_duty  <= stg_duty_nxt;
                act_phase <= stg_phase_nxt;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_phase_channel #(
            .CTR_W  (CTR_W),
            .PERIOD (PERIOD)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .ctr     (ctr),
            .duty    (act_duty[g]),
            .phase   (act_phase[g]),
            .pwm_out (pwm_out[g])
        );
    end

endmodule
